mem_tbus_arbiter: RTL and testbench

Shares the single dcache trinity-bus (tbus) port between the load unit and the store queue inside the memory subsystem. It accepts one request at a time, registers its payload, and drives the downstream port. It then routes the completion back to the owner and cleans up load transactions killed by a redirect flush. It sits between the loadunit/storequeue tbus outputs and the dcache.

---
 rtl/mem_tbus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_tbus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tbus_arbiter.sv
// Arbitrates the single dcache tbus port between load unit and store queue (store aging under TBUS_ARB_AGING_EN).
// Latency: grant in N, dc_index_valid in N+1, done combinational from dc_operation_done; 3 cycles/txn minimum.
// Backpressure: one txn outstanding; readies only in IDLE to the winner; payload held until dc_index_ready.

`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 3:0
`endif

module mem_tbus_arbiter #(
    parameter int AGE_LIMIT = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,

    input  logic                       ld_index_valid,
    output logic                       ld_index_ready,
    input  logic [63:0]                ld_index,
    input  logic [63:0]                ld_write_data,
    input  logic [63:0]                ld_write_mask,
    input  logic [`TBUS_OPTYPE_RANGE]  ld_operation_type,
    input  logic                       ld_flush_valid,
    output logic [63:0]                ld_read_data,
    output logic                       ld_operation_done,

    input  logic                       sq_index_valid,
    output logic                       sq_index_ready,
    input  logic [63:0]                sq_index,
    input  logic [63:0]                sq_write_data,
    input  logic [63:0]                sq_write_mask,
    input  logic [`TBUS_OPTYPE_RANGE]  sq_operation_type,
    output logic [63:0]                sq_read_data,
    output logic                       sq_operation_done,

    output logic                       dc_index_valid,
    input  logic                       dc_index_ready,
    output logic [63:0]                dc_index,
    output logic [63:0]                dc_write_data,
    output logic [63:0]                dc_write_mask,
    output logic [`TBUS_OPTYPE_RANGE]  dc_operation_type,
    input  logic [63:0]                dc_read_data,
    input  logic                       dc_operation_done,

    output logic                       arb_owner
);

    if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_age_limit_check
        $error("mem_tbus_arbiter: AGE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   store_wins;
    logic   age_fire;
    logic   grant_ld;
    logic   grant_sq;
    logic   flush_ld;

`ifdef TBUS_ARB_AGING_EN
    localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);

    logic [3:0] age_cnt;

    // Counts loads that overtook a waiting store; never passes AGE_LIM because the store then wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            age_cnt <= '0;
        end else if (grant_sq) begin
            age_cnt <= '0;
        end else if (grant_ld && sq_index_valid) begin
            age_cnt <= age_cnt + 4'd1;
        end
    end

    assign age_fire = sq_index_valid && (age_cnt == AGE_LIM);
`else
    assign age_fire = 1'b0;
`endif

    // Readies are gated by valid so an idle arbiter presents no readies at all.
    always_comb begin
        store_wins     = !ld_index_valid || age_fire;
        ld_index_ready = (state == IDLE) && ld_index_valid && !store_wins && !ld_flush_valid;
        sq_index_ready = (state == IDLE) && sq_index_valid && store_wins;
        grant_ld       = ld_index_ready;
        grant_sq       = sq_index_ready;
        // Committed stores are never killed, so a flush only matters for a load-owned txn.
        flush_ld       = ld_flush_valid && !arb_owner;
    end

    always_comb begin
        state_nxt         = state;
        dc_index_valid    = 1'b0;
        ld_operation_done = 1'b0;
        sq_operation_done = 1'b0;

        case (state)
            IDLE: begin
                if (grant_ld || grant_sq) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dc_index_valid = 1'b1;
                if (dc_index_ready) begin
                    state_nxt = flush_ld ? DRAIN : WAIT;
                end else if (flush_ld) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (flush_ld) begin
                    // A completion coinciding with the flush retires the killed load silently.
                    state_nxt = dc_operation_done ? IDLE : DRAIN;
                end else if (dc_operation_done) begin
                    state_nxt         = IDLE;
                    ld_operation_done = !arb_owner;
                    sq_operation_done = arb_owner;
                end
            end
            DRAIN: begin
                if (dc_operation_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            arb_owner         <= 1'b0;
            dc_index          <= '0;
            dc_write_data     <= '0;
            dc_write_mask     <= '0;
            dc_operation_type <= '0;
        end else if (grant_ld || grant_sq) begin
            arb_owner         <= grant_sq;
            dc_index          <= grant_sq ? sq_index          : ld_index;
            dc_write_data     <= grant_sq ? sq_write_data     : ld_write_data;
            dc_write_mask     <= grant_sq ? sq_write_mask     : ld_write_mask;
            dc_operation_type <= grant_sq ? sq_operation_type : ld_operation_type;
        end
    end

    assign ld_read_data = dc_read_data;
    assign sq_read_data = dc_read_data;

endmodule

// File: tb/tb_mem_tbus_arbiter.sv
// Directed, table-driven bench for mem_tbus_arbiter plus hand-written aging and reset sequences.

`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 3:0
`endif

module tb_mem_tbus_arbiter;

    localparam logic [63:0] LD_IDX = 64'h0000_0000_8000_1000;
    localparam logic [63:0] SQ_IDX = 64'h0000_0000_9000_2000;
    localparam logic [63:0] LD_WD  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] SQ_WD  = 64'h2222_2222_2222_2222;
    localparam logic [63:0] DB     = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] Z      = 64'h0;
    localparam int          NV     = 30;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic                      ld_index_valid, ld_index_ready, ld_flush_valid, ld_operation_done;
    logic [63:0]               ld_index, ld_write_data, ld_write_mask, ld_read_data;
    logic [`TBUS_OPTYPE_RANGE] ld_operation_type;
    logic                      sq_index_valid, sq_index_ready, sq_operation_done;
    logic [63:0]               sq_index, sq_write_data, sq_write_mask, sq_read_data;
    logic [`TBUS_OPTYPE_RANGE] sq_operation_type;
    logic                      dc_index_valid, dc_index_ready, dc_operation_done;
    logic [63:0]               dc_index, dc_write_data, dc_write_mask, dc_read_data;
    logic [`TBUS_OPTYPE_RANGE] dc_operation_type;
    logic                      arb_owner;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    mem_tbus_arbiter #(.AGE_LIMIT(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ld_index_valid    (ld_index_valid),
        .ld_index_ready    (ld_index_ready),
        .ld_index          (ld_index),
        .ld_write_data     (ld_write_data),
        .ld_write_mask     (ld_write_mask),
        .ld_operation_type (ld_operation_type),
        .ld_flush_valid    (ld_flush_valid),
        .ld_read_data      (ld_read_data),
        .ld_operation_done (ld_operation_done),
        .sq_index_valid    (sq_index_valid),
        .sq_index_ready    (sq_index_ready),
        .sq_index          (sq_index),
        .sq_write_data     (sq_write_data),
        .sq_write_mask     (sq_write_mask),
        .sq_operation_type (sq_operation_type),
        .sq_read_data      (sq_read_data),
        .sq_operation_done (sq_operation_done),
        .dc_index_valid    (dc_index_valid),
        .dc_index_ready    (dc_index_ready),
        .dc_index          (dc_index),
        .dc_write_data     (dc_write_data),
        .dc_write_mask     (dc_write_mask),
        .dc_operation_type (dc_operation_type),
        .dc_read_data      (dc_read_data),
        .dc_operation_done (dc_operation_done),
        .arb_owner         (arb_owner)
    );

    typedef struct {
        logic        ldv, fl, sqv, rdy, done;
        logic [63:0] rdata;
        logic        e_ldr, e_sqr, e_dcv, e_own, e_ldd, e_sqd;
        logic [63:0] e_idx;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic ldv, fl, sqv, rdy, done, input logic [63:0] rdata,
                                input logic ldr, sqr, dcv, own, ldd, sqd, input logic [63:0] idx);
        vec_t v;
        v.ldv = ldv; v.fl = fl; v.sqv = sqv; v.rdy = rdy; v.done = done; v.rdata = rdata;
        v.e_ldr = ldr; v.e_sqr = sqr; v.e_dcv = dcv; v.e_own = own;
        v.e_ldd = ldd; v.e_sqd = sqd; v.e_idx = idx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          ngr;
        int          gcyc [5];
        logic        gkind [5];
        logic        exp_kind;
`ifdef TBUS_ARB_AGING_EN
        logic [3:0]  age_at_last;
        age_at_last = '0;
`endif

        //            ldv fl sqv rdy dn rdata | ldr sqr dcv own ldd sqd idx
        tbl[0]  = mk(1, 0, 0, 1, 0, Z,    1, 0, 0, 0, 0, 0, Z);
        tbl[1]  = mk(0, 0, 0, 1, 0, Z,    0, 0, 1, 0, 0, 0, LD_IDX);
        tbl[2]  = mk(0, 0, 0, 1, 0, Z,    0, 0, 0, 0, 0, 0, LD_IDX);
        tbl[3]  = mk(0, 0, 0, 1, 1, DB,   0, 0, 0, 0, 1, 0, LD_IDX);
        tbl[4]  = mk(0, 0, 0, 1, 0, Z,    0, 0, 0, 0, 0, 0, LD_IDX);
        tbl[5]  = mk(1, 0, 1, 1, 0, Z,    1, 0, 0, 0, 0, 0, LD_IDX);
        tbl[6]  = mk(0, 0, 1, 1, 0, Z,    0, 0, 1, 0, 0, 0, LD_IDX);
        tbl[7]  = mk(0, 0, 1, 1, 1, DB,   0, 0, 0, 0, 1, 0, LD_IDX);
        tbl[8]  = mk(0, 0, 1, 1, 0, Z,    0, 1, 0, 0, 0, 0, LD_IDX);
        tbl[9]  = mk(0, 0, 0, 1, 0, Z,    0, 0, 1, 1, 0, 0, SQ_IDX);
        tbl[10] = mk(0, 0, 0, 1, 1, DB,   0, 0, 0, 1, 0, 1, SQ_IDX);
        tbl[11] = mk(0, 0, 0, 1, 0, Z,    0, 0, 0, 1, 0, 0, SQ_IDX);
        tbl[12] = mk(1, 0, 1, 0, 0, Z,    1, 0, 0, 1, 0, 0, SQ_IDX);
        tbl[13] = mk(0, 1, 1, 0, 0, Z,    0, 0, 1, 0, 0, 0, LD_IDX);
        tbl[14] = mk(0, 0, 1, 0, 0, Z,    0, 1, 0, 0, 0, 0, LD_IDX);
        tbl[15] = mk(0, 0, 0, 1, 0, Z,    0, 0, 1, 1, 0, 0, SQ_IDX);
        tbl[16] = mk(0, 0, 0, 1, 1, DB,   0, 0, 0, 1, 0, 1, SQ_IDX);
        tbl[17] = mk(0, 0, 0, 1, 0, Z,    0, 0, 0, 1, 0, 0, SQ_IDX);
        tbl[18] = mk(1, 0, 0, 1, 0, Z,    1, 0, 0, 1, 0, 0, SQ_IDX);
        tbl[19] = mk(0, 0, 0, 1, 0, Z,    0, 0, 1, 0, 0, 0, LD_IDX);
        tbl[20] = mk(0, 1, 0, 1, 0, Z,    0, 0, 0, 0, 0, 0, LD_IDX);
        tbl[21] = mk(0, 0, 0, 1, 1, DB,   0, 0, 0, 0, 0, 0, LD_IDX);
        tbl[22] = mk(0, 0, 1, 1, 0, Z,    0, 1, 0, 0, 0, 0, LD_IDX);
        tbl[23] = mk(0, 1, 0, 1, 0, Z,    0, 0, 1, 1, 0, 0, SQ_IDX);
        tbl[24] = mk(0, 1, 0, 1, 1, DB,   0, 0, 0, 1, 0, 1, SQ_IDX);
        tbl[25] = mk(1, 1, 0, 1, 0, Z,    0, 0, 0, 1, 0, 0, SQ_IDX);
        tbl[26] = mk(1, 0, 0, 1, 0, Z,    1, 0, 0, 1, 0, 0, SQ_IDX);
        tbl[27] = mk(0, 1, 0, 1, 0, Z,    0, 0, 1, 0, 0, 0, LD_IDX);
        tbl[28] = mk(0, 0, 0, 1, 1, DB,   0, 0, 0, 0, 0, 0, LD_IDX);
        tbl[29] = mk(0, 0, 0, 1, 1, DB,   0, 0, 0, 0, 0, 0, LD_IDX);

        reset_n           = 1'b0;
        ld_index_valid    = 1'b0;
        ld_flush_valid    = 1'b0;
        ld_index          = LD_IDX;
        ld_write_data     = LD_WD;
        ld_write_mask     = 64'h0000_0000_0000_00FF;
        ld_operation_type = 1;
        sq_index_valid    = 1'b0;
        sq_index          = SQ_IDX;
        sq_write_data     = SQ_WD;
        sq_write_mask     = 64'h0000_0000_0000_000F;
        sq_operation_type = 2;
        dc_index_ready    = 1'b0;
        dc_read_data      = Z;
        dc_operation_done = 1'b0;

        #3;
        chk("reset_dc_vld",   dc_index_valid,    0);
        chk("reset_ld_rdy",   ld_index_ready,    0);
        chk("reset_sq_rdy",   sq_index_ready,    0);
        chk("reset_ld_done",  ld_operation_done, 0);
        chk("reset_sq_done",  sq_operation_done, 0);
        chk("reset_owner",    arb_owner,         0);
        chk("reset_dc_index", dc_index,          0);
        chk("reset_dc_wdata", dc_write_data,     0);

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < NV; i++) begin
            ld_index_valid    = tbl[i].ldv;
            ld_flush_valid    = tbl[i].fl;
            sq_index_valid    = tbl[i].sqv;
            dc_index_ready    = tbl[i].rdy;
            dc_operation_done = tbl[i].done;
            dc_read_data      = tbl[i].rdata;
            #3;
            chk($sformatf("v%0d_ld_rdy", i),  ld_index_ready,    tbl[i].e_ldr);
            chk($sformatf("v%0d_sq_rdy", i),  sq_index_ready,    tbl[i].e_sqr);
            chk($sformatf("v%0d_dc_vld", i),  dc_index_valid,    tbl[i].e_dcv);
            chk($sformatf("v%0d_owner", i),   arb_owner,         tbl[i].e_own);
            chk($sformatf("v%0d_ld_done", i), ld_operation_done, tbl[i].e_ldd);
            chk($sformatf("v%0d_sq_done", i), sq_operation_done, tbl[i].e_sqd);
            chk($sformatf("v%0d_dc_idx", i),  dc_index,          tbl[i].e_idx);
            if (tbl[i].e_dcv)
                chk($sformatf("v%0d_dc_wdata", i), dc_write_data, tbl[i].e_own ? SQ_WD : LD_WD);
            if (tbl[i].e_ldd)
                chk($sformatf("v%0d_ld_rdata", i), ld_read_data, DB);
            if (tbl[i].e_sqd)
                chk($sformatf("v%0d_sq_rdata", i), sq_read_data, DB);
            @(posedge clock);
            #1;
        end

        // Continuous loads and stores; stray dones outside WAIT are ignored by the arbiter.
        ld_index_valid    = 1'b1;
        sq_index_valid    = 1'b1;
        ld_flush_valid    = 1'b0;
        dc_index_ready    = 1'b1;
        dc_operation_done = 1'b1;
        dc_read_data      = Z;
        ngr = 0;
        for (int c = 0; c < 40 && ngr < 5; c++) begin
            #3;
            if ((ld_index_valid && ld_index_ready) || (sq_index_valid && sq_index_ready)) begin
                gcyc[ngr]  = c;
                gkind[ngr] = sq_index_ready;
`ifdef TBUS_ARB_AGING_EN
                age_at_last = dut.age_cnt;
`endif
                ngr++;
            end
            @(posedge clock);
            #1;
        end
        chk("aging_grant_count", ngr, 5);
        for (int k = 0; k < ngr; k++) begin
`ifdef TBUS_ARB_AGING_EN
            exp_kind = (k == 4);
`else
            exp_kind = 1'b0;
`endif
            chk($sformatf("aging_grant%0d_kind", k), gkind[k], exp_kind);
            if (k > 0)
                chk($sformatf("aging_grant%0d_gap", k), gcyc[k] - gcyc[k-1], 3);
        end
        ld_index_valid = 1'b0;
        sq_index_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        dc_operation_done = 1'b0;
`ifdef TBUS_ARB_AGING_EN
        chk("aging_cnt_at_store_grant", age_at_last, 4);
        chk("aging_cnt_after", dut.age_cnt, 0);
`endif

        // Reset asserted mid-WAIT on a store with its completion pending.
        sq_index_valid = 1'b1;
        #3 chk("rst_seq_sq_rdy", sq_index_ready, 1);
        @(posedge clock);
        #1 sq_index_valid = 1'b0;
        @(posedge clock);
        #1;
        dc_operation_done = 1'b1;
        dc_read_data      = DB;
        #1;
        chk("rst_seq_pre_sq_done", sq_operation_done, 1);
        chk("rst_seq_pre_owner",   arb_owner,         1);
        reset_n           = 1'b0;
        dc_read_data      = Z;
        #1;
        chk("rst_async_dc_vld",  dc_index_valid,    0);
        chk("rst_async_ld_rdy",  ld_index_ready,    0);
        chk("rst_async_sq_rdy",  sq_index_ready,    0);
        chk("rst_async_ld_done", ld_operation_done, 0);
        chk("rst_async_sq_done", sq_operation_done, 0);
        chk("rst_async_owner",   arb_owner,         0);
        chk("rst_async_dc_idx",  dc_index,          0);
        chk("rst_async_dc_wd",   dc_write_data,     0);
        dc_operation_done = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        ld_index_valid = 1'b1;
        #3 chk("post_rst_ld_rdy", ld_index_ready, 1);
        @(posedge clock);
        #1 ld_index_valid = 1'b0;
        #3;
        chk("post_rst_dc_vld",    dc_index_valid,    1);
        chk("post_rst_owner",     arb_owner,         0);
        chk("post_rst_dc_idx",    dc_index,          LD_IDX);
        chk("post_rst_dc_optype", dc_operation_type, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
